// File: rtl/debounce_pkg.sv
// Shared types and helpers for the push-button debounce controller.
// Channel state encoding plus a constant-evaluable ceillog2.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  function automatic int ceillog2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_debouncer.sv
// Free-running modulo-N_MAX counter; counter_match is a registered
// one-cycle pulse every N_MAX clocks, first one after the N_MAX-th edge.
module counter_debouncer
  import debounce_pkg::*;
#(
  parameter int N_MAX = 5000
) (
  input  logic clk,
  input  logic rst_a_p,
  output logic counter_match
);

  localparam int CW = (N_MAX > 1) ? ceillog2(N_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          match_q, match_d;

  always_comb begin
    match_d = (cnt_q == LAST);
    cnt_d   = match_d ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign counter_match = match_q;

endmodule

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, tick-sampled agreement FSM,
// registered level and single-cycle press/release strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW = ceillog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] ST_C = CW'(STABLE_TICKS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]    sync_q, sync_d;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          sync;

  assign sync    = sync_q[1];
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        RELEASED: begin
          if (sync) begin
            if (STABLE_TICKS == 1) begin
              state_d = PRESSED;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_PEND;
              cnt_d   = ONE;
            end
          end
        end
        PRESS_PEND: begin
          if (!sync) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_inc == ST_C) begin
            state_d = PRESSED;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!sync) begin
            if (STABLE_TICKS == 1) begin
              state_d = RELEASED;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end else begin
              state_d = RELEASE_PEND;
              cnt_d   = ONE;
            end
          end
        end
        RELEASE_PEND: begin
          if (sync) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == ST_C) begin
            state_d = RELEASED;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: rtl/debounce_ctrl.sv
// Multi-channel jog-button debouncer: one shared sample tick
// drives an independent debounce FSM per button.
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int N_MAX        = 5000,
  parameter int STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_a_p,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             tick
);

  logic tick_w;

  counter_debouncer #(
    .N_MAX(N_MAX)
  ) u_tick (
    .clk          (clk),
    .rst_a_p      (rst_a_p),
    .counter_match(tick_w)
  );

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst_a_p    (rst_a_p),
      .tick       (tick_w),
      .btn_raw    (btn_in[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g])
    );
  end

  assign tick = tick_w;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl: vector table, corner sequences and a
// random run checked against a run-length reference model.
module tb_debounce_ctrl;

  localparam int NB = 4;
  localparam int NM = 4;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] lvl, prs, rel;
  logic          tck;
  logic [NB-1:0] btn1 = '0;
  logic [NB-1:0] lvl1, prs1, rel1;
  logic          tck1;

  always #5 clk = ~clk;

  debounce_ctrl #(
    .N_BTN(NB), .N_MAX(NM), .STABLE_TICKS(ST)
  ) dut (
    .clk        (clk),
    .rst_a_p    (rst),
    .btn_in     (btn),
    .btn_level  (lvl),
    .btn_press  (prs),
    .btn_release(rel),
    .tick       (tck)
  );

  debounce_ctrl #(
    .N_BTN(NB), .N_MAX(NM), .STABLE_TICKS(1)
  ) dut1 (
    .clk        (clk),
    .rst_a_p    (rst),
    .btn_in     (btn1),
    .btn_level  (lvl1),
    .btn_press  (prs1),
    .btn_release(rel1),
    .tick       (tck1)
  );

  int tests = 0;
  int fails = 0;

  // reference: count consecutive tick samples disagreeing with level
  int            m_edges;
  logic [NB-1:0] d0, d1;
  logic [NB-1:0] m_lvl, m_prs, m_rel;
  logic          m_tick;
  int            run [NB];

  typedef struct {
    logic [NB-1:0] btn;
    int            hold;
    logic [NB-1:0] lv;
    logic [NB-1:0] pr;
    logic [NB-1:0] rl;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    d0 = '0;
    d1 = '0;
    m_lvl = '0;
    m_prs = '0;
    m_rel = '0;
    m_tick = 1'b0;
    for (int i = 0; i < NB; i++) run[i] = 0;
  endtask

  task automatic cyc();
    logic          ct;
    logic [NB-1:0] cs;
    ct = (m_edges > 0) && (m_edges % NM == 0);
    cs = d1;
    m_prs = '0;
    m_rel = '0;
    if (ct) begin
      for (int i = 0; i < NB; i++) begin
        if (cs[i] !== m_lvl[i]) begin
          run[i]++;
          if (run[i] == ST) begin
            m_lvl[i] = cs[i];
            if (cs[i]) m_prs[i] = 1'b1;
            else m_rel[i] = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    d1 = d0;
    d0 = btn;
    m_edges++;
    m_tick = (m_edges % NM == 0);
    @(posedge clk);
    #1;
    check($sformatf("model_cycle%0d", m_edges),
          32'({tck, lvl, prs, rel}),
          32'({m_tick, m_lvl, m_prs, m_rel}));
    check($sformatf("excl_cycle%0d", m_edges), 32'(prs & rel), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async_out", 32'({tck, lvl, prs, rel}), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_out", 32'({tck, lvl, prs, rel}), 32'd0);
    check("rst_held_out1", 32'({tck1, lvl1, prs1, rel1}), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int            ntick;
    logic [NB-1:0] acc;
    model_reset();

    tbl[0] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 11, 4'b0001, 4'b0001, 4'b0000};
    tbl[2] = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000};
    tbl[3] = '{4'b0100, 11, 4'b0100, 4'b0100, 4'b0001};
    tbl[4] = '{4'b0100,  1, 4'b0100, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0110,  7, 4'b0100, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0100,  4, 4'b0100, 4'b0000, 4'b0000};
    tbl[7] = '{4'b0110, 11, 4'b0100, 4'b0000, 4'b0000};
    tbl[8] = '{4'b0110,  1, 4'b0110, 4'b0010, 4'b0000};
    tbl[9] = '{4'b0000, 12, 4'b0000, 4'b0000, 4'b0110};

    // idle: ticks every NM cycles, outputs quiet
    btn = '0;
    do_reset();
    ntick = 0;
    acc = '0;
    repeat (40) begin
      cyc();
      if (tck) ntick++;
      acc = acc | lvl | prs | rel;
    end
    check("idle_tick_count", 32'(ntick), 32'd10);
    check("idle_outputs", 32'(acc), 32'd0);

    // press latency on channel 0
    btn = '0;
    do_reset();
    repeat (9) cyc();
    btn = 4'b0001;
    repeat (11) cyc();
    check("press0_early", 32'(prs), 32'd0);
    cyc();
    check("press0_strobe", 32'(prs), 32'b0001);
    check("press0_level", 32'(lvl), 32'b0001);
    cyc();
    check("press0_width", 32'(prs), 32'd0);
    check("press0_hold", 32'(lvl), 32'b0001);

    // vector table
    btn = '0;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      btn = tbl[r].btn;
      repeat (tbl[r].hold) cyc();
      check($sformatf("tbl%0d_level", r), 32'(lvl), 32'(tbl[r].lv));
      check($sformatf("tbl%0d_press", r), 32'(prs), 32'(tbl[r].pr));
      check($sformatf("tbl%0d_release", r), 32'(rel), 32'(tbl[r].rl));
    end

    // reset during a pending press
    btn = 4'b0001;
    do_reset();
    repeat (5) cyc();
    btn = 4'b1001;
    repeat (9) cyc();
    check("pre_reset_level", 32'(lvl), 32'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_clear", 32'({tck, lvl, prs, rel}), 32'd0);
    @(posedge clk);
    #1;
    check("mid_reset_hold", 32'({tck, lvl, prs, rel}), 32'd0);
    rst = 1'b0;
    model_reset();
    repeat (12) cyc();
    check("fresh_early", 32'(prs), 32'd0);
    cyc();
    check("fresh_press", 32'(prs), 32'b1001);
    check("fresh_level", 32'(lvl), 32'b1001);

    // single-tick agreement variant
    btn = '0;
    btn1 = '0;
    do_reset();
    btn1 = 4'b0001;
    repeat (4) cyc();
    check("st1_early", 32'(prs1), 32'd0);
    cyc();
    check("st1_press", 32'(prs1), 32'b0001);
    check("st1_level", 32'(lvl1), 32'b0001);
    btn1 = '0;
    repeat (4) cyc();
    check("st1_release", 32'(rel1), 32'b0001);
    check("st1_level_off", 32'(lvl1), 32'd0);
    check("st1_tick", 32'(tck1), 32'(tck));

    // random run with slow changes and short glitches
    btn = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
